// File: rtl/alu_seq_exec.sv
// Sequential execute stage: one-cycle logic/arithmetic ops, bit-serial shifts.
// valid/ready on both sides; results are held in DONE until downstream takes them.
module alu_seq_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_valid,
  output logic             out_ready,
  input  logic [2:0]       in_alu_control,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             in_result_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [1:0]       out_dbg_state
);

  // Handshake: an op is accepted on an edge where in_valid && out_ready; a result
  // is taken on an edge where out_valid && in_result_ready. Both flags decode the
  // state register only, so neither depends combinationally on the other side.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_shr;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  logic             w_accept;
  logic             w_is_shift;
  logic [SHW-1:0]   w_amt;
  logic             w_start_shift;
  logic             w_last;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_sh_next;

  assign w_amt         = in_b[SHW-1:0];
  assign w_is_shift    = (in_alu_control[2:1] == 2'b11);
  assign w_accept      = in_valid && (r_state == S_IDLE);
  assign w_start_shift = w_is_shift && (w_amt != '0);
  assign w_last        = (r_cnt == {{(SHW-1){1'b0}}, 1'b1});
  assign w_sh_next     = r_shr ? (r_work >> 1) : (r_work << 1);

  // Shift opcodes only land here with amount 0, so they pass operand A through.
  always_comb begin
    w_alu = in_a;
    case (in_alu_control)
      OP_ADD:  w_alu = in_a + in_b;
      OP_SUB:  w_alu = in_a - in_b;
      OP_AND:  w_alu = in_a & in_b;
      OP_OR:   w_alu = in_a | in_b;
      OP_XOR:  w_alu = in_a ^ in_b;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      default: w_alu = in_a;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = w_start_shift ? S_SHIFT : S_DONE;
      S_SHIFT: if (w_last) w_next_state = S_DONE;
      S_DONE:  if (in_result_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    out_ready     = (r_state == S_IDLE);
    out_valid     = (r_state == S_DONE);
    out_dbg_state = r_state;
  end

  // Only the shift direction is needed after accept; the other opcode bits are
  // fully consumed by the single-cycle path.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_shr    <= 1'b0;
      r_work   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shr <= in_alu_control[0];
            if (w_start_shift) begin
              r_work <= in_a;
              r_cnt  <= w_amt;
            end else begin
              r_result <= w_alu;
              r_zero   <= (w_alu == '0);
            end
          end
        end
        S_SHIFT: begin
          r_work <= w_sh_next;
          r_cnt  <= r_cnt - 1'b1;
          if (w_last) begin
            r_result <= w_sh_next;
            r_zero   <= (w_sh_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_result = r_result;
  assign out_zero   = r_zero;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Bench for alu_seq_exec: directed scenarios plus a random stream scored against
// an arithmetic reference model with an expected queue.
module tb_alu_seq_exec;

  localparam int W = 32;

  logic         in_clk = 1'b0;
  logic         in_rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready;
  logic [2:0]   in_alu_control = 3'd0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         in_result_ready = 1'b1;
  logic [W-1:0] out_result;
  logic         out_zero;
  logic [1:0]   out_dbg_state;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  alu_seq_exec #(.WIDTH(W)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid), .out_ready(out_ready),
    .in_alu_control(in_alu_control), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .in_result_ready(in_result_ready),
    .out_result(out_result), .out_zero(out_zero), .out_dbg_state(out_dbg_state)
  );

  always #5 in_clk = ~in_clk;

  function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int amt;
    amt = int'(b % W);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 1 : 0;
      3'd6: return a << amt;
      default: return a >> amt;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [W-1:0] b);
    if (op >= 3'd6) return 1 + int'(b % W);
    return 1;
  endfunction

  // Called just after a negedge with the block idle; returns just after a negedge, idle again.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic z, output int lat);
    in_alu_control = op; in_a = a; in_b = b;
    in_valid = 1'b1; in_result_ready = 1'b1;
    @(posedge in_clk); @(negedge in_clk);
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_alu_control = 3'($urandom_range(0, 7));
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge in_clk); lat++;
    end
    res = out_result; z = out_zero;
    @(posedge in_clk); @(negedge in_clk);
  endtask

  task automatic test_reset();
    logic [W-1:0] res; logic z; int lat; bit seen;
    in_rst = 1'b1;
    repeat (2) @(posedge in_clk);
    @(negedge in_clk);
    in_rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", out_ready); end
    checks++; if (out_result !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", out_result); end
    checks++; if (out_zero !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b exp=0", out_zero); end
    issue(3'd0, 32'd3, 32'd4, res, z, lat);
    checks++; if (res !== 32'd7) begin failures++; $display("FAIL pre_reset_add got=%h exp=7", res); end
    in_alu_control = 3'd6; in_a = 32'h0000_1234; in_b = 32'd20; in_valid = 1'b1;
    @(posedge in_clk); @(negedge in_clk);
    in_valid = 1'b0;
    repeat (5) @(negedge in_clk);
    in_rst = 1'b1;
    repeat (2) @(posedge in_clk);
    @(negedge in_clk);
    in_rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midop_reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_ready !== 1'b1) begin failures++; $display("FAIL midop_reset_ready got=%b exp=1", out_ready); end
    checks++; if (out_result !== '0) begin failures++; $display("FAIL midop_reset_result got=%h exp=0", out_result); end
    checks++; if (out_zero !== 1'b0) begin failures++; $display("FAIL midop_reset_zero got=%b exp=0", out_zero); end
    seen = 0;
    repeat (40) begin
      @(negedge in_clk);
      if (out_valid) seen = 1;
    end
    checks++; if (seen) begin failures++; $display("FAIL midop_reset_ghost got=1 exp=0"); end
  endtask

  task automatic test_arith();
    logic [W-1:0] res; logic z; int lat;
    issue(3'd0, 32'hFFFF_FFFF, 32'd1, res, z, lat);
    checks++; if (res !== 32'd0) begin failures++; $display("FAIL add_wrap got=%h exp=0", res); end
    checks++; if (z !== 1'b1) begin failures++; $display("FAIL add_zero got=%b exp=1", z); end
    checks++; if (lat != 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", lat); end
    issue(3'd1, 32'd5, 32'd7, res, z, lat);
    checks++; if (res !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sub got=%h exp=fffffffe", res); end
    checks++; if (z !== 1'b0) begin failures++; $display("FAIL sub_zero got=%b exp=0", z); end
    issue(3'd5, 32'hFFFF_FFFF, 32'd1, res, z, lat);
    checks++; if (res !== 32'd1) begin failures++; $display("FAIL slt_neg got=%h exp=1", res); end
    issue(3'd5, 32'd1, 32'hFFFF_FFFF, res, z, lat);
    checks++; if (res !== 32'd0 || z !== 1'b1) begin failures++; $display("FAIL slt_pos got=%h/%b exp=0/1", res, z); end
  endtask

  task automatic test_logic();
    logic [W-1:0] res; logic z; int lat;
    issue(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, res, z, lat);
    checks++; if (res !== 32'hF000_F000 || lat != 1) begin failures++; $display("FAIL and got=%h lat=%0d exp=f000f000 lat=1", res, lat); end
    issue(3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, res, z, lat);
    checks++; if (res !== 32'hFFF0_FFF0 || lat != 1) begin failures++; $display("FAIL or got=%h lat=%0d exp=fff0fff0 lat=1", res, lat); end
    issue(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, res, z, lat);
    checks++; if (res !== 32'h0FF0_0FF0 || lat != 1) begin failures++; $display("FAIL xor got=%h lat=%0d exp=0ff00ff0 lat=1", res, lat); end
  endtask

  task automatic test_shift();
    logic [W-1:0] res; logic z; int lat;
    issue(3'd6, 32'h1, 32'd31, res, z, lat);
    checks++; if (res !== 32'h8000_0000) begin failures++; $display("FAIL sll31 got=%h exp=80000000", res); end
    checks++; if (lat != 32) begin failures++; $display("FAIL sll31_latency got=%0d exp=32", lat); end
    issue(3'd7, 32'h8000_0000, 32'd4, res, z, lat);
    checks++; if (res !== 32'h0800_0000 || lat != 5) begin failures++; $display("FAIL srl4 got=%h lat=%0d exp=08000000 lat=5", res, lat); end
    issue(3'd6, 32'hDEAD_BEEF, 32'h20, res, z, lat);
    checks++; if (res !== 32'hDEAD_BEEF || lat != 1) begin failures++; $display("FAIL sll0 got=%h lat=%0d exp=deadbeef lat=1", res, lat); end
    issue(3'd7, 32'h0000_00F0, 32'd8, res, z, lat);
    checks++; if (res !== 32'd0 || z !== 1'b1) begin failures++; $display("FAIL srl_zero got=%h/%b exp=0/1", res, z); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] res; logic z; int lat; logic [1:0] st0;
    in_alu_control = 3'd2; in_a = 32'hF0F0_F0F0; in_b = 32'hFF00_FF00;
    in_valid = 1'b1; in_result_ready = 1'b0;
    @(posedge in_clk); @(negedge in_clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", out_valid); end
    st0 = out_dbg_state;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_alu_control = 3'($urandom_range(0, 7)); in_a = $urandom; in_b = $urandom;
      @(posedge in_clk); @(negedge in_clk);
      checks++; if (out_result !== 32'hF000_F000 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold cyc=%0d got=%h/%b exp=f000f000/1", i, out_result, out_valid); end
      checks++; if (out_ready !== 1'b0) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, out_ready); end
      checks++; if (out_dbg_state !== st0) begin failures++; $display("FAIL bp_state cyc=%0d got=%0d exp=%0d", i, out_dbg_state, st0); end
    end
    in_valid = 1'b0; in_result_ready = 1'b1;
    @(posedge in_clk); @(negedge in_clk);
    checks++; if (out_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b/%b exp=ready1/valid0", out_ready, out_valid); end
    issue(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, res, z, lat);
    checks++; if (res !== 32'h0FF0_0FF0) begin failures++; $display("FAIL bp_next got=%h exp=0ff00ff0", res); end
  endtask

  task automatic test_back_to_back();
    int sent, got, cyc, acc_cyc, exp_lat;
    bit seen;
    logic [2:0] op;
    sent = 0; got = 0; cyc = 0; acc_cyc = 0; exp_lat = 0; seen = 1;
    exp_q.delete();
    while (got < 1000 && cyc < 60000) begin
      @(negedge in_clk);
      cyc++;
      checks++; if (out_ready !== (exp_q.size() == 0)) begin failures++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, out_ready, exp_q.size() == 0); end
      if (out_valid) begin
        if (!seen) begin
          seen = 1;
          checks++; if (cyc - acc_cyc != exp_lat) begin failures++; $display("FAIL b2b_latency op#%0d got=%0d exp=%0d", got, cyc - acc_cyc, exp_lat); end
        end
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_spurious got=%h exp=none", out_result); end
        else if (out_result !== exp_q[0] || out_zero !== (exp_q[0] == '0)) begin
          failures++; $display("FAIL b2b_result op#%0d got=%h/%b exp=%h/%b", got, out_result, out_zero, exp_q[0], exp_q[0] == '0);
        end
      end
      in_valid = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      op = 3'($urandom_range(0, 7));
      in_alu_control = op; in_a = $urandom; in_b = $urandom;
      if ($urandom_range(0, 3) == 0) in_b = in_a;
      in_result_ready = 1'($urandom_range(0, 1));
      if (out_valid && in_result_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        got++;
      end
      if (in_valid && out_ready) begin
        exp_q.push_back(ref_res(op, in_a, in_b));
        exp_lat = ref_lat(op, in_b);
        acc_cyc = cyc; seen = 0; sent++;
      end
    end
    in_valid = 1'b0; in_result_ready = 1'b1;
    checks++; if (got != 1000 || exp_q.size() != 0) begin failures++; $display("FAIL b2b_count got=%0d pending=%0d exp=1000/0", got, exp_q.size()); end
    @(negedge in_clk);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_backpressure();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_exec.md
# alu_seq_exec

Sequential execute stage sitting directly downstream of the ALU control decoder: it consumes the decoder's 3-bit ALU control code together with two operands and produces a registered result and zero flag. It exchanges operands and results with valid/ready handshakes. Logic ops take one cycle. Shifts iterate one bit per cycle, so no barrel shifter is needed.

## Interface
- WIDTH, 32, operand/result width in bits; must be a power of two ≥ 8.
- SHW, $clog2(WIDTH), shift-amount width in bits; derived, do not override.

- in_clk  input  1  clock; all state changes on the rising edge.
- in_rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  upstream presents an operation.
- out_ready  output  1  block can accept an operation; high only in IDLE.
- in_alu_control  input  3  operation code from the ALU control decoder.
- in_a  input  WIDTH  operand A (rs1 value).
- in_b  input  WIDTH  operand B (rs2 value or immediate); the shift amount is in_b[SHW-1:0].
- out_valid  output  1  result available.
- in_result_ready  input  1  downstream accepts the result.
- out_result  output  WIDTH  result.
- out_zero  output  1  high when out_result == 0.

## Operation
- **Opcodes:**
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT (signed, result 1 or 0)
  - 110 SLL
  - 111 SRL (logical, zero-fill)
- **Arithmetic:** ADD and SUB are modulo 2^WIDTH; carry and overflow are discarded.
- **States:** IDLE, SHIFT, DONE.
- **IDLE:** out_ready=1 and out_valid=0. Accept occurs when in_valid && out_ready. On accept, the block latches the opcode, in_a and the shift amount.
  - Non-shift op, or shift with amount 0: compute the result and go to DONE.
  - Shift with amount k>0: working register = in_a, counter = k, go to SHIFT.
- **SHIFT:** each cycle, shift the working register by 1 in the opcode's direction and decrement the counter. When the counter is 1 (the last shift), go to DONE.
- **DONE:** out_valid=1. out_result and out_zero are held stable until in_result_ready=1, then the block goes to IDLE.
- **Ignored inputs:** in_valid is ignored outside IDLE. Input operands are sampled only on accept; later changes have no effect.
- **out_zero:** registered from the same value as out_result.

## Timing
- **Reset:** takes effect at the next edge and wins over every other event. State becomes IDLE; out_valid=0, out_ready=1, out_result=0, out_zero=0; any in-flight op is discarded.
- **Latency, non-shift or zero-amount shift:** accept at edge of cycle N → out_valid=1 in cycle N+1.
- **Latency, shift by k:** SHIFT occupies cycles N+1..N+k; out_valid=1 in cycle N+1+k. Maximum k is WIDTH-1.
- **Result hand-off:** the result is taken at the edge where out_valid && in_result_ready. The block is in IDLE (out_ready=1) the following cycle.
- **Throughput:** minimum 2 cycles per op with downstream always ready. There is no accept in the same cycle a result is taken.
- **Downstream stall:** the block stays in DONE indefinitely with outputs unchanged.
- **Reset mid-op:** reset asserted in SHIFT or DONE returns to IDLE next cycle with out_valid=0, and no result is delivered.
- **Output glitching:** out_ready and out_valid are decoded from the state register only and never depend combinationally on in_valid or in_result_ready.

## Test plan
- **Reset:** hold in_rst for 2 cycles during a SHIFT of k=20 → next cycle out_valid=0, out_ready=1, out_result=0, out_zero=0; no result ever appears for that op.
- **Arithmetic and zero flag:** ADD 0xFFFFFFFF+1 → out_result=0, out_zero=1 at N+1. SUB 5−7 → 0xFFFFFFFE, out_zero=0. SLT −1 vs 1 → 1.
- **Logic ops:** AND 0xF0F0F0F0,0xFF00FF00 → 0xF000F000. OR of the same operands → 0xFFF0FFF0. XOR of the same operands → 0x0FF00FF0. Each appears one cycle after accept.
- **Shift latency:** SLL 0x1 by 31 → 0x80000000, out_valid exactly 32 cycles after accept. SRL 0x80000000 by 4 → 0x08000000 at N+5. SLL by in_b=0x20 (amount 0) → in_a unchanged at N+1.
- **Backpressure:** hold in_result_ready=0 for 10 cycles after out_valid → out_result stable and out_ready=0 throughout, even with in_valid=1 and changing operands. Release → IDLE next cycle, then a new op is accepted.
- **Back-to-back:** random stream of 1000 ops against a reference model, with random in_valid and in_result_ready → every result matches, in order, with no drops or duplicates.
